x_fwd_flush_ctrl: RTL
=====================

// Module: x_fwd_flush_ctrl
// PURPOSE
//  Parametrised execute-stage control for the RV32/RV64 pipeline: tracks the last HIST_DEPTH
//  retiring instructions in a history shift register, selects per-operand forwarding sources,
//  resolves branches/jumps, runs a multi-cycle flush FSM and generates store byte lanes/data.
//  Sits between D and X stages; drives X-stage operand muxes, PC select and DMEM write enables.
// PARAMETERS
//  XLEN          32  datapath width, 32 or 64 (64 adds SD)
//  HIST_DEPTH    2   older instructions tracked for forwarding, >=2
//  FLUSH_CYCLES  2   advancing cycles with flush high per redirect, incl. redirect cycle, >=1
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high
//  adv          in   1          pipeline advance request this cycle
//  x_valid      in   1          x_inst is a real instruction
//  x_inst       in   32         instruction in X
//  br_eq        in   1          comparator equal
//  br_lt        in   1          comparator less-than (signedness per br_un)
//  addr_offset  in   LOG2(XLEN/8)  low bits of store/load address
//  rs2_data     in   XLEN       forwarded rs2 value for stores
//  fwd_a_sel    out  CLOG2(HIST_DEPTH+1)  0=regfile, k=k-th most recent history entry
//  fwd_b_sel    out  CLOG2(HIST_DEPTH+1)  same for rs2
//  a_is_pc      out  1          ALU A = PC (branch, JAL, AUIPC)
//  b_is_imm     out  1          ALU B = imm (all except R-type)
//  br_un        out  1          unsigned compare (BLTU/BGEU)
//  pc_sel       out  1          redirect PC to ALU result
//  flush        out  1          kill younger stages
//  stall        out  1          hold F/D/X this cycle
//  dmem_re      out  1          load read enable
//  dmem_we      out  XLEN/8     store byte-lane enables
//  store_data   out  XLEN       lane-aligned store data
//  st_misalign  out  1          misaligned SH/SW/SD detected; no write issued
// BEHAVIOUR
//  - History entry: {valid, rd, wr_rd, is_load}; wr_rd=0 for BRANCH/STORE; rd==0 never matches.
//  - eff_adv = adv & ~stall. On eff_adv: entry1 <= decode(X) (valid = x_valid & ~kill), entry k+1 <= k.
//    On adv & stall: entry1 <= bubble, older entries still shift. No shift when adv=0.
//  - fwd_x_sel = smallest k with valid & wr_rd & rd==rsX; 0 if none. rs2 ignored for I/LOAD/JALR/CSR.
//  - kill = flush-FSM in FLUSH or ~x_valid: X acts as bubble: pc_sel, dmem_re, dmem_we, stall all 0.
//  - Branch: BEQ/BNE on br_eq, BLT/BGE/BLTU/BGEU on br_lt; br_un=1 for U forms; invalid funct3 = not taken.
//  - pc_sel=1 for taken branch, JAL, JALR (combinational, same cycle).
//  - Flush FSM: IDLE, FLUSH(cnt). IDLE & pc_sel & eff_adv -> FLUSH, cnt=FLUSH_CYCLES-1 (stay IDLE if 0).
//    FLUSH: cnt decrements on adv; cnt==1 & adv -> IDLE. flush = pc_sel | (state==FLUSH).
//  - Stores: SB lane=offset; SH lanes {offset[..1],0}+1:0; SW 4 lanes; SD (XLEN=64) all lanes.
//    Data replicated into selected lanes, others 0. SH offset[0]=1, SW offset[1:0]!=0, SD offset!=0:
//    dmem_we=0, st_misalign=1.
//  - Loads: dmem_re=1, dmem_we=0.
//  - Reset: history all invalid, FSM IDLE; while reset=1 all outputs 0. Reset mid-FLUSH -> IDLE.
//  - All outputs combinational from state + inputs; latency 0; state updates on clk edge.
// CONFIGURATION
//  X_LOAD_USE_STALL_EN defined: if entry1 is_load and matches a used X source, stall=1 for one
//   cycle (entry1 bubble shifts in); next cycle load sits in entry2, fwd_sel=2, stall=0.
//  Undefined: stall tied 0; load in entry1 forwarded with fwd_sel=1 (single-cycle DMEM read).
// TESTING
//  1 add x5 then add x6,x5,x5 -> fwd_a_sel=1, fwd_b_sel=1; one nop between -> both =2.
//  2 sw x5 then add x7,x5,x0 -> fwd_a_sel=0 (stores never forward); rd=x0 producer never forwards.
//  3 beq taken (br_eq=1), FLUSH_CYCLES=2 -> pc_sel=1, flush=1 that cycle and next adv cycle, then 0;
//    instruction behind it issues no dmem_we and no pc_sel.
//  4 sb addr_offset=2 rs2=0x1234_56AB -> dmem_we=4'b0100, store_data=0x00AB_0000; sh offset=1 -> we=0, st_misalign=1.
//  5 lw x8 then add x9,x8,x1 with X_LOAD_USE_STALL_EN -> stall=1 one cycle, then fwd_a_sel=2, stall=0.
//  6 reset asserted mid-FLUSH with pending history -> next cycle flush=0, fwd sels 0, FSM IDLE.

Source files
------------

// File: rtl/x_fwd_flush_ctrl.sv
// x_fwd_flush_ctrl: X-stage forwarding select, branch resolution, flush FSM and store lane generation.
// Optional feature: define X_LOAD_USE_STALL_EN to stall one cycle on a load-use hazard against entry1.
module x_fwd_flush_ctrl #(
  parameter int XLEN         = 32,
  parameter int HIST_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            adv,
  input  logic                            x_valid,
  input  logic [31:0]                     x_inst,
  input  logic                            br_eq,
  input  logic                            br_lt,
  input  logic [$clog2(XLEN/8)-1:0]       addr_offset,
  input  logic [XLEN-1:0]                 rs2_data,
  output logic [$clog2(HIST_DEPTH+1)-1:0] fwd_a_sel,
  output logic [$clog2(HIST_DEPTH+1)-1:0] fwd_b_sel,
  output logic                            a_is_pc,
  output logic                            b_is_imm,
  output logic                            br_un,
  output logic                            pc_sel,
  output logic                            flush,
  output logic                            stall,
  output logic                            dmem_re,
  output logic [XLEN/8-1:0]               dmem_we,
  output logic [XLEN-1:0]                 store_data,
  output logic                            st_misalign
);
  localparam int LANES = XLEN / 8;
  localparam int SEL_W = $clog2(HIST_DEPTH + 1);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_rd;
    logic       is_load;
  } hist_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  hist_t            hist [HIST_DEPTH];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       unused_funct7;

  assign opcode        = x_inst[6:0];
  assign rd            = x_inst[11:7];
  assign funct3        = x_inst[14:12];
  assign rs1           = x_inst[19:15];
  assign rs2           = x_inst[24:20];
  assign unused_funct7 = ^x_inst[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_op, is_op_imm, is_op32, is_op_imm32, is_system, is_csr;
  logic uses_rs1, uses_rs2, wr_rd;

  assign is_lui      = (opcode == OPC_LUI);
  assign is_auipc    = (opcode == OPC_AUIPC);
  assign is_jal      = (opcode == OPC_JAL);
  assign is_jalr     = (opcode == OPC_JALR);
  assign is_branch   = (opcode == OPC_BRANCH);
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_op       = (opcode == OPC_OP);
  assign is_op_imm   = (opcode == OPC_OP_IMM);
  assign is_op32     = (opcode == OPC_OP32);
  assign is_op_imm32 = (opcode == OPC_OP_IMM32);
  assign is_system   = (opcode == OPC_SYSTEM);
  assign is_csr      = is_system & (funct3 != 3'b000);

  // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field, not a register.
  assign uses_rs1 = is_jalr | is_branch | is_load | is_store | is_op | is_op_imm |
                    is_op32 | is_op_imm32 | (is_csr & ~funct3[2]);
  assign uses_rs2 = is_branch | is_store | is_op | is_op32;
  assign wr_rd    = is_lui | is_auipc | is_jal | is_jalr | is_load | is_op | is_op_imm |
                    is_op32 | is_op_imm32 | is_csr;

  logic kill;
  assign kill = (state == FLUSH) | ~x_valid;

  logic br_taken, redirect, pc_sel_int;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = ~br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = ~br_lt;
      default:        br_taken = 1'b0;
    endcase
  end

  assign redirect   = (is_branch & br_taken) | is_jal | is_jalr;
  assign pc_sel_int = ~kill & redirect;

  logic [SEL_W-1:0] fwd_a_int, fwd_b_int;

  // Walk oldest to newest so the youngest matching producer wins.
  always_comb begin
    fwd_a_int = '0;
    fwd_b_int = '0;
    for (int k = HIST_DEPTH; k >= 1; k--) begin
      if (hist[k-1].valid && hist[k-1].wr_rd && (hist[k-1].rd != 5'd0)) begin
        if (uses_rs1 && (hist[k-1].rd == rs1)) fwd_a_int = SEL_W'(k);
        if (uses_rs2 && (hist[k-1].rd == rs2)) fwd_b_int = SEL_W'(k);
      end
    end
  end

  logic stall_int, eff_adv;

`ifdef X_LOAD_USE_STALL_EN
  assign stall_int = ~kill & hist[0].valid & hist[0].is_load & hist[0].wr_rd &
                     (hist[0].rd != 5'd0) &
                     ((uses_rs1 & (hist[0].rd == rs1)) | (uses_rs2 & (hist[0].rd == rs2)));
`else
  logic unused_oldest_load;
  assign unused_oldest_load = hist[HIST_DEPTH-1].is_load;
  assign stall_int = 1'b0;
`endif

  assign eff_adv = adv & ~stall_int;

  logic [LANES-1:0] lanes;
  logic [XLEN-1:0]  rep_data;
  logic             misalign;

  always_comb begin
    lanes    = '0;
    rep_data = '0;
    misalign = 1'b0;
    if (is_store) begin
      case (funct3)
        3'b000: begin
          rep_data = {LANES{rs2_data[7:0]}};
          lanes    = LANES'(1) << addr_offset;
        end
        3'b001: begin
          rep_data = {(LANES/2){rs2_data[15:0]}};
          if (addr_offset[0]) misalign = 1'b1;
          else                lanes    = LANES'(2'b11) << addr_offset;
        end
        3'b010: begin
          rep_data = {(LANES/4){rs2_data[31:0]}};
          if (addr_offset[1:0] != 2'b00) misalign = 1'b1;
          else                           lanes    = LANES'(4'hF) << addr_offset;
        end
        3'b011: begin
          if (XLEN == 64) begin
            rep_data = rs2_data;
            if (addr_offset != '0) misalign = 1'b1;
            else                   lanes    = '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fwd_a_sel   = reset ? '0 : fwd_a_int;
  assign fwd_b_sel   = reset ? '0 : fwd_b_int;
  assign a_is_pc     = ~reset & (is_branch | is_jal | is_auipc);
  assign b_is_imm    = ~reset & ~(is_op | is_op32);
  assign br_un       = ~reset & is_branch & (funct3[2:1] == 2'b11);
  assign pc_sel      = ~reset & pc_sel_int;
  assign flush       = ~reset & (pc_sel_int | (state == FLUSH));
  assign stall       = ~reset & stall_int;
  assign dmem_re     = ~reset & ~kill & is_load;
  assign dmem_we     = (reset | kill) ? '0 : lanes;
  assign st_misalign = ~reset & ~kill & misalign;

  // Data is driven only on lanes actually written; idle lanes read as zero.
  always_comb begin
    store_data = '0;
    for (int i = 0; i < LANES; i++) begin
      store_data[i*8 +: 8] = dmem_we[i] ? rep_data[i*8 +: 8] : 8'h00;
    end
  end

  // A stalled advance shifts a bubble into entry1 while older entries keep ageing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else if (adv) begin
      for (int k = HIST_DEPTH - 1; k >= 1; k--) hist[k] <= hist[k-1];
      hist[0] <= stall_int ? hist_t'('0) : hist_t'({~kill, rd, wr_rd, is_load});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_sel_int && eff_adv && (FLUSH_CYCLES > 1)) begin
            state <= FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (adv) begin
            if (cnt == CNT_W'(1)) state <= IDLE;
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
